peripheral_arbiter_bb: RTL and testbench
========================================

PERIPHERAL_ARBITER_BB -- requirements
Module: peripheral_arbiter_bb

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width; DW/8 select lanes.
REQ-003 Parameter NUM_MASTERS, default 4: requester count, 2..8.
REQ-004 Parameter TIMEOUT, default 255: stalled-cycle watchdog limit, 1..65535.
REQ-005 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-006 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-007 m_adr_i  in  NUM_MASTERS*AW  per-master address; master k in slice [k*AW +: AW]; same packing for all m_* vectors.
REQ-008 m_dat_i  in  NUM_MASTERS*DW  per-master write data.
REQ-009 m_sel_i  in  NUM_MASTERS*DW/8  per-master byte select.
REQ-010 m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master write enable, cycle, strobe.
REQ-011 m_cti_i  in  NUM_MASTERS*3; m_bte_i  in  NUM_MASTERS*2  per-master burst tags.
REQ-012 m_dat_o  out  DW  read data, broadcast to all masters.
REQ-013 m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master termination.
REQ-014 s_adr_o AW, s_dat_o DW, s_sel_o DW/8, s_we_o 1, s_cyc_o 1, s_stb_o 1, s_cti_o 3, s_bte_o 2  out  shared slave port.
REQ-015 s_dat_i DW, s_ack_i 1, s_err_i 1, s_rty_i 1  in  slave responses.
REQ-016 grant_o  out  NUM_MASTERS  one-hot current owner, zero when idle.

Function
REQ-017 FSM states IDLE and OWNED; register grant (one-hot), rr_ptr (clog2(NUM_MASTERS) bits), wd_cnt (16 bits).
REQ-018 IDLE: on a rising edge with any m_cyc_i high, grant the first requester found scanning rr_ptr, rr_ptr+1, ... mod NUM_MASTERS; enter OWNED.
REQ-019 Grant latency: one cycle from m_cyc_i to s_cyc_o for an uncontended master.
REQ-020 OWNED: s_* outputs combinationally mux the granted master's adr/dat/sel/we/cyc/stb/cti/bte.
REQ-021 OWNED: m_ack_o/m_err_o/m_rty_o of the granted master equal s_ack_i/s_err_i/s_rty_i; all other masters' terminations 0.
REQ-022 m_dat_o = s_dat_i always.
REQ-023 IDLE: all s_* outputs and all m_ack_o/m_err_o/m_rty_o 0; grant_o 0.
REQ-024 Release: owner deasserting m_cyc_i in OWNED -> IDLE on that edge; rr_ptr = (owner+1) mod NUM_MASTERS; no preemption while owner keeps m_cyc_i high, including across bursts (cti 001/010) and after cti 111.
REQ-025 Back-to-back owners: minimum one IDLE cycle between releases and new grants.
REQ-026 Simultaneous requests resolve only by rr_ptr; a waiting master is granted within NUM_MASTERS-1 intervening ownerships.
REQ-027 Watchdog: in OWNED, wd_cnt increments each cycle owner stb high and no s_ack_i/s_err_i/s_rty_i; clears on any termination, stb low, or leaving OWNED.
REQ-028 When wd_cnt reaches TIMEOUT: drive m_err_o of owner high for exactly one cycle, s_stb_o forced 0 that cycle, wd_cnt cleared; ownership retained.
REQ-029 A slave termination coinciding with timeout takes priority; no watchdog error that cycle.

Reset
REQ-030 wb_rst_i high: immediately state IDLE, grant 0, rr_ptr 0, wd_cnt 0; all outputs 0 (m_dat_o follows s_dat_i).
REQ-031 Reset mid-transfer aborts it without termination to the master; after release, arbitration restarts from rr_ptr 0.

Verification
REQ-032 Single master 1 classic write adr 0x10, data 0xCAFEF00D -> s_cyc_o high one cycle after m_cyc_i[1]; ack routed only to m_ack_o[1]; grant_o 0b0010.
REQ-033 Masters 0..3 request together from reset -> grant order 0,1,2,3, each separated by one IDLE cycle.
REQ-034 Master 2 issues 8-beat incrementing burst (cti 010, last 111) while master 0 requests -> master 0 granted only after master 2 drops cyc; no beats interleaved.
REQ-035 TIMEOUT=4, slave never acks -> m_err_o of owner pulses once after 4 stalled cycles, repeats every 5 cycles while stb held.
REQ-036 Assert wb_rst_i mid-burst of master 3 -> all outputs 0 asynchronously; after reset, pending masters 1 and 3 granted in order 1, 3.

Source files
------------

// File: rtl/peripheral_arbiter_bb.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// Owner holds the bus until it drops cyc; a watchdog errors stalled beats.
module peripheral_arbiter_bb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [15:0]            wd_q, wd_d;

  logic [IW-1:0] own_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          own_cyc;
  logic          own_stb;
  logic          term;
  logic          wd_fire;
  int            scan;

  // State registers; reset drops any transfer in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  // Find the first requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan = (int'(rr_q) + k) % NUM_MASTERS;
      if (!pick_found && m_cyc_i[scan]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(scan);
      end
    end
  end

  // Route the owner's request onto the slave port.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (state_q == OWNED && grant_q[k]) begin
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_we_o  = m_we_i[k];
        s_cti_o = m_cti_i[k*3 +: 3];
        s_bte_o = m_bte_i[k*2 +: 2];
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_idx = IW'(k);
      end
    end
  end

  // A slave termination always beats the watchdog.
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire = (state_q == OWNED) && own_stb && !term &&
                   (wd_q == 16'(TIMEOUT));
  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_stb & ~wd_fire;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  // Terminations go only to the owner.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == OWNED) begin
      m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
      m_err_o = grant_q & {NUM_MASTERS{s_err_i | wd_fire}};
      m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
    end
  end

  // Grant, release and watchdog sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_found) begin
          state_d           = OWNED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          wd_d    = '0;
          rr_d    = (own_idx == IW'(NUM_MASTERS - 1)) ?
                    '0 : own_idx + IW'(1);
        end else if (term || !own_stb || wd_fire) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_peripheral_arbiter_bb.sv
// Scoreboard bench for peripheral_arbiter_bb.
// Planned beats queue up in round-robin order; a monitor checks each ack.
module tb_peripheral_arbiter_bb;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]    grant_o;

  logic [31:0] ma_adr [NM];
  logic [31:0] ma_dat [NM];
  logic [3:0]  ma_sel [NM];
  logic        ma_we  [NM];
  logic        ma_cyc [NM];
  logic        ma_stb [NM];
  logic [2:0]  ma_cti [NM];
  logic [1:0]  ma_bte [NM];

  for (genvar k = 0; k < NM; k++) begin : g_pack
    assign m_adr_i[k*AW +: AW] = ma_adr[k];
    assign m_dat_i[k*DW +: DW] = ma_dat[k];
    assign m_sel_i[k*4 +: 4]   = ma_sel[k];
    assign m_we_i[k]           = ma_we[k];
    assign m_cyc_i[k]          = ma_cyc[k];
    assign m_stb_i[k]          = ma_stb[k];
    assign m_cti_i[k*3 +: 3]   = ma_cti[k];
    assign m_bte_i[k*2 +: 2]   = ma_bte[k];
  end

  peripheral_arbiter_bb #(
    .AW(AW), .DW(DW), .NUM_MASTERS(NM), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    int          owner;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } beat_t;

  beat_t  plan [NM][8];
  int     nb [NM];
  beat_t  exp_q [$];
  beat_t  mon_e;
  int     rr_m;
  int     rd_cur [NM];
  bit     rd_done [NM];
  int     stall, stall_tgt;
  bit     slave_mute;
  logic [NM-1:0] prev_g;
  int     checks;
  int     failures;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Reference arbitration: first pending master from the pointer on.
  function automatic int rr_first(logic [NM-1:0] pend);
    for (int i = 0; i < NM; i++)
      if (pend[(rr_m + i) % NM]) return (rr_m + i) % NM;
    return -1;
  endfunction

  function automatic void plan_rand(int k, int n);
    nb[k] = n;
    for (int b = 0; b < n; b++) begin
      plan[k][b].adr = $urandom;
      plan[k][b].dat = $urandom;
      plan[k][b].sel = 4'($urandom_range(0, 15));
      plan[k][b].we  = 1'($urandom_range(0, 1));
      plan[k][b].bte = 2'($urandom_range(0, 3));
      plan[k][b].cti = (n == 1) ? 3'b000 :
                       (b == n - 1) ? 3'b111 : 3'b010;
    end
  endfunction

  function automatic void drive_masters();
    for (int k = 0; k < NM; k++) begin
      if (!rd_done[k]) begin
        ma_cyc[k] = 1'b1;
        ma_stb[k] = 1'b1;
        ma_adr[k] = plan[k][rd_cur[k]].adr;
        ma_dat[k] = plan[k][rd_cur[k]].dat;
        ma_sel[k] = plan[k][rd_cur[k]].sel;
        ma_we[k]  = plan[k][rd_cur[k]].we;
        ma_cti[k] = plan[k][rd_cur[k]].cti;
        ma_bte[k] = plan[k][rd_cur[k]].bte;
      end else begin
        ma_cyc[k] = 1'b0;
        ma_stb[k] = 1'b0;
      end
    end
  endfunction

  function automatic void slave_step();
    s_dat_i = $urandom;
    s_ack_i = 1'b0;
    if (!slave_mute && s_cyc_o && s_stb_o) begin
      if (stall >= stall_tgt) begin
        s_ack_i   = 1'b1;
        stall     = 0;
        stall_tgt = $urandom_range(0, 2);
      end else begin
        stall++;
      end
    end
  endfunction

  function automatic void idle_masters();
    for (int k = 0; k < NM; k++) begin
      ma_cyc[k] = 1'b0; ma_stb[k] = 1'b0; ma_we[k] = 1'b0;
      ma_adr[k] = '0; ma_dat[k] = '0; ma_sel[k] = '0;
      ma_cti[k] = '0; ma_bte[k] = '0;
    end
  endfunction

  // Entered and left at posedge+1 with the arbiter idle.
  task automatic run_round(input logic [NM-1:0] mask);
    logic [NM-1:0] pend;
    logic [NM-1:0] ackd;
    int            first;
    int            m;
    bit            all_done;
    beat_t         e;
    pend  = mask;
    first = rr_first(mask);
    while (pend != '0) begin
      m = rr_first(pend);
      pend[m] = 1'b0;
      for (int b = 0; b < nb[m]; b++) begin
        e = plan[m][b];
        e.owner = m;
        exp_q.push_back(e);
      end
      rr_m = (m + 1) % NM;
    end
    for (int k = 0; k < NM; k++) begin
      rd_cur[k]  = 0;
      rd_done[k] = !mask[k];
    end
    drive_masters();
    for (int c = 0; ; c++) begin
      @(negedge wb_clk_i);
      ackd = m_ack_o;
      @(posedge wb_clk_i);
      #1;
      s_ack_i = 1'b0;
      if (c == 0) begin
        chk("grant_latency", 64'(s_cyc_o), 64'(1));
        chk("first_owner", 64'(grant_o), 64'(1) << first);
      end
      for (int k = 0; k < NM; k++)
        if (!rd_done[k] && ackd[k]) begin
          rd_cur[k]++;
          if (rd_cur[k] == nb[k]) rd_done[k] = 1'b1;
        end
      drive_masters();
      #1;
      slave_step();
      all_done = 1'b1;
      for (int k = 0; k < NM; k++)
        if (!rd_done[k]) all_done = 1'b0;
      if (all_done) break;
      if (c > 400) begin
        checks++;
        failures++;
        $display("FAIL round_timeout actual=%0d required<=400", c);
        break;
      end
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    logic [NM-1:0] mask;
    bit            exp_err;
    checks     = 0;
    failures   = 0;
    rr_m       = 0;
    stall      = 0;
    stall_tgt  = 0;
    slave_mute = 1'b0;
    prev_g     = '0;
    idle_masters();
    s_dat_i  = 32'h1234_5678;
    s_ack_i  = 1'b1;
    s_err_i  = 1'b0;
    s_rty_i  = 1'b0;
    wb_rst_i = 1'b1;

    fork
      forever begin
        @(negedge wb_clk_i);
        if (wb_rst_i) begin
          prev_g = '0;
        end else begin
          if (grant_o != prev_g) begin
            chk("grant_gap", 64'(prev_g != 0 && grant_o != 0), 64'(0));
            chk("grant_onehot", 64'($countones(grant_o) <= 1), 64'(1));
            prev_g = grant_o;
          end
          if (s_cyc_o && s_stb_o && s_ack_i) begin
            chk("dat_bcast", 64'(m_dat_o), 64'(s_dat_i));
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_beat actual=grant 0x%0h required=none",
                       grant_o);
            end else begin
              mon_e = exp_q.pop_front();
              chk("beat_owner", 64'(grant_o), 64'(1) << mon_e.owner);
              chk("beat_ack", 64'(m_ack_o), 64'(1) << mon_e.owner);
              chk("beat_adr", 64'(s_adr_o), 64'(mon_e.adr));
              chk("beat_dat", 64'(s_dat_o), 64'(mon_e.dat));
              chk("beat_sel", 64'(s_sel_o), 64'(mon_e.sel));
              chk("beat_we", 64'(s_we_o), 64'(mon_e.we));
              chk("beat_cti", 64'(s_cti_o), 64'(mon_e.cti));
              chk("beat_bte", 64'(s_bte_o), 64'(mon_e.bte));
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_ack", 64'(m_ack_o), 64'(0));
    chk("rst_dat", 64'(m_dat_o), 64'(32'h1234_5678));
    s_ack_i  = 1'b0;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;

    for (int k = 0; k < NM; k++) plan_rand(k, 1);
    run_round(4'b1111);

    nb[1] = 1;
    plan[1][0].adr = 32'h10;
    plan[1][0].dat = 32'hCAFE_F00D;
    plan[1][0].sel = 4'hF;
    plan[1][0].we  = 1'b1;
    plan[1][0].cti = 3'b000;
    plan[1][0].bte = 2'b00;
    run_round(4'b0010);

    plan_rand(0, 1);
    plan_rand(2, 8);
    for (int b = 0; b < 8; b++) begin
      plan[2][b].adr = 32'h2000 + 32'(b * 4);
      plan[2][b].bte = 2'b00;
    end
    run_round(4'b0101);

    slave_mute = 1'b1;
    ma_cyc[3] = 1'b1; ma_stb[3] = 1'b1;
    ma_adr[3] = 32'h300; ma_we[3] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      exp_err = (i % (TO + 1)) == 0;
      chk("wd_err", 64'(m_err_o), exp_err ? 64'(4'b1000) : 64'(0));
      chk("wd_stb", 64'(s_stb_o), exp_err ? 64'(0) : 64'(1));
    end
    @(posedge wb_clk_i);
    #1;
    ma_cyc[3] = 1'b0; ma_stb[3] = 1'b0;
    @(posedge wb_clk_i);
    #1;
    rr_m = 0;
    slave_mute = 1'b0;

    repeat (30) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < NM; k++) plan_rand(k, $urandom_range(1, 4));
      run_round(mask);
    end

    slave_mute = 1'b1;
    ma_cyc[3] = 1'b1; ma_stb[3] = 1'b1;
    ma_cti[3] = 3'b010; ma_adr[3] = 32'h3000;
    @(posedge wb_clk_i);
    #1;
    chk("pre_rst_owner", 64'(grant_o), 64'(4'b1000));
    ma_cyc[1] = 1'b1; ma_stb[1] = 1'b1; ma_adr[1] = 32'h100;
    @(posedge wb_clk_i);
    #3;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_grant", 64'(grant_o), 64'(0));
    chk("arst_cyc", 64'(s_cyc_o), 64'(0));
    chk("arst_stb", 64'(s_stb_o), 64'(0));
    chk("arst_adr", 64'(s_adr_o), 64'(0));
    chk("arst_term", 64'({m_ack_o, m_err_o, m_rty_o}), 64'(0));
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    rr_m = 0;
    mask = 4'b1010;
    @(posedge wb_clk_i);
    #1;
    chk("post_rst_first", 64'(grant_o), 64'(1) << rr_first(mask));
    rr_m = rr_first(mask) + 1;
    mask[1] = 1'b0;
    ma_cyc[1] = 1'b0; ma_stb[1] = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("post_rst_gap", 64'(grant_o), 64'(0));
    @(posedge wb_clk_i);
    #1;
    chk("post_rst_second", 64'(grant_o), 64'(1) << rr_first(mask));
    ma_cyc[3] = 1'b0; ma_stb[3] = 1'b0;
    @(posedge wb_clk_i);
    #1;
    slave_mute = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
